// File: rtl/sliding_window_pkg.sv
// ============================================================================
// Module      : sliding_window_pkg
// Description : Shared types and sizing helpers for sliding_window and its
//               frame controller (frame state encoding, row/col widths).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sliding_window_pkg;

  // Frame sequencing states of the controller
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2,
    RESYNC = 2'd3
  } frame_state_e;

  // Bits needed to index 0..extent-1; never returns zero so a 1-wide
  // dimension still gets a real (constant-zero) counter bit.
  function automatic int unsigned pos_bits(input int unsigned extent);
    return (extent > 1) ? $clog2(extent) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_position_counter.sv
// ============================================================================
// Module      : frame_position_counter
// Description : Raster row/column counter for one HEIGHT x WIDTH frame.
//               Flags the first (0,0) and last (HEIGHT-1,WIDTH-1) pixels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_position_counter
  import sliding_window_pkg::*;
#(
  parameter int HEIGHT = 600,
  parameter int WIDTH  = 800,
  localparam int ROW_W = pos_bits(HEIGHT),
  localparam int COL_W = pos_bits(WIDTH)
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             first_o,
  output logic             last_o
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  // Raster advance: column wraps into the next row, last pixel wraps to (0,0)
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      row <= '0;
      col <= '0;
    end else if (clear_i) begin
      row <= '0;
      col <= '0;
    end else if (advance_i) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign row_o   = row;
  assign col_o   = col;
  assign first_o = (row == '0) && (col == '0);
  assign last_o  = (row == ROW_LAST) && (col == COL_LAST);

endmodule

`default_nettype wire

// File: rtl/sliding_window_frame_controller.sv
// ============================================================================
// Module      : sliding_window_frame_controller
// Description : Frame sequencer in front of sliding_window. Checks SOF/EOF
//               framing against HEIGHT x WIDTH, forwards aligned beats with a
//               regenerated tlast, holds the window in reset between frames
//               and drops misaligned data until the next SOF.
//               Optional build macro SLIDING_WINDOW_FRAME_STATS_EN adds
//               frame_count_o / error_count_o statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sliding_window_frame_controller
  import sliding_window_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int HEIGHT     = 600,
  parameter int WIDTH      = 800
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  enable_i,
  input  logic                  slave_tvalid_i,
  output logic                  slave_tready_o,
  input  logic [DATA_WIDTH-1:0] slave_tdata_i,
  input  logic                  slave_tuser_i,
  input  logic                  slave_tlast_i,
  output logic                  master_tvalid_o,
  input  logic                  master_tready_i,
  output logic [DATA_WIDTH-1:0] master_tdata_o,
  output logic                  master_tlast_o,
  output logic                  window_reset_o,
  output logic                  frame_done_o,
  output logic                  error_o
`ifdef SLIDING_WINDOW_FRAME_STATS_EN
  ,
  output logic [31:0]           frame_count_o,
  output logic [15:0]           error_count_o
`endif
);

  localparam int ROW_W = pos_bits(HEIGHT);
  localparam int COL_W = pos_bits(WIDTH);

  frame_state_e     state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             first;
  logic             last;
  logic             in_stream;
  logic             err_now;
  logic             take;
  logic             good_beat;
  logic             bad_beat;
  logic             unused_pos;

  frame_position_counter #(
    .HEIGHT (HEIGHT),
    .WIDTH  (WIDTH)
  ) u_pos (
    .clock_i   (clock_i),
    .reset_ni  (reset_ni),
    .clear_i   (state == ARM),
    .advance_i (good_beat),
    .row_o     (row),
    .col_o     (col),
    .first_o   (first),
    .last_o    (last)
  );

  // Raw coordinates are only needed through the first/last flags here
  assign unused_pos = ^{row, col};

  assign in_stream = (state == STREAM);

  // Framing flags must match the position exactly: SOF only at (0,0), EOF only at the end
  assign err_now   = (first != slave_tuser_i) || (slave_tlast_i != last);

  // A beat the downstream could accept this cycle; error beats are never forwarded
  assign take      = in_stream && slave_tvalid_i && master_tready_i;
  assign good_beat = take && !err_now;
  assign bad_beat  = take && err_now;

  // Upstream ready: a misplaced SOF is held back so it can restart the next frame
  always_comb begin
    slave_tready_o = 1'b0;
    case (state)
      STREAM:  slave_tready_o = master_tready_i && !(err_now && slave_tuser_i);
      RESYNC:  slave_tready_o = !slave_tuser_i;
      default: slave_tready_o = 1'b0;
    endcase
  end

  assign master_tvalid_o = in_stream && slave_tvalid_i && !err_now;
  assign master_tdata_o  = slave_tdata_i;
  assign master_tlast_o  = in_stream && last;

  // Frame sequencer with registered window reset, done pulse and sticky error
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state          <= IDLE;
      window_reset_o <= 1'b1;
      frame_done_o   <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      frame_done_o <= good_beat && last;

      if (!enable_i) begin
        error_o <= 1'b0;
      end else if (bad_beat) begin
        error_o <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable_i) begin
            state          <= ARM;
            window_reset_o <= 1'b1;
          end
        end
        ARM: begin
          state          <= STREAM;
          window_reset_o <= 1'b0;
        end
        STREAM: begin
          if (good_beat && last) begin
            state          <= enable_i ? ARM : IDLE;
            window_reset_o <= 1'b1;
          end else if (bad_beat) begin
            if (slave_tuser_i) begin
              state          <= ARM;
              window_reset_o <= 1'b1;
            end else begin
              state          <= RESYNC;
              window_reset_o <= 1'b0;
            end
          end
        end
        RESYNC: begin
          if (!enable_i) begin
            state          <= IDLE;
            window_reset_o <= 1'b1;
          end else if (slave_tvalid_i && slave_tuser_i) begin
            state          <= ARM;
            window_reset_o <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          window_reset_o <= 1'b1;
        end
      endcase
    end
  end

`ifdef SLIDING_WINDOW_FRAME_STATS_EN
  // Completed-frame and framing-error event counters; error count saturates
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      frame_count_o <= '0;
      error_count_o <= '0;
    end else begin
      if (good_beat && last) begin
        frame_count_o <= frame_count_o + 32'd1;
      end
      if (bad_beat && (error_count_o != 16'hFFFF)) begin
        error_count_o <= error_count_o + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sliding_window_frame_controller.sv
// ============================================================================
// Module      : tb_sliding_window_frame_controller
// Description : Self-checking bench for sliding_window_frame_controller with a
//               4x5 frame: table of directed framing cases, mid-frame reset,
//               and randomized frame streams against a sequence-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sliding_window_frame_controller;

  localparam int DW = 8;
  localparam int H  = 4;
  localparam int W  = 5;
  localparam int N  = H * W;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          enable   = 1'b0;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata  = '0;
  logic          s_tuser  = 1'b0;
  logic          s_tlast  = 1'b0;
  logic          m_tready = 1'b0;
  logic          s_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          win_reset;
  logic          frame_done;
  logic          error;
`ifdef SLIDING_WINDOW_FRAME_STATS_EN
  logic [31:0]   frame_count;
  logic [15:0]   error_count;
`endif

  sliding_window_frame_controller #(
    .DATA_WIDTH (DW),
    .HEIGHT     (H),
    .WIDTH      (W)
  ) dut (
    .clock_i         (clk),
    .reset_ni        (rst_n),
    .enable_i        (enable),
    .slave_tvalid_i  (s_tvalid),
    .slave_tready_o  (s_tready),
    .slave_tdata_i   (s_tdata),
    .slave_tuser_i   (s_tuser),
    .slave_tlast_i   (s_tlast),
    .master_tvalid_o (m_tvalid),
    .master_tready_i (m_tready),
    .master_tdata_o  (m_tdata),
    .master_tlast_o  (m_tlast),
    .window_reset_o  (win_reset),
    .frame_done_o    (frame_done),
    .error_o         (error)
`ifdef SLIDING_WINDOW_FRAME_STATS_EN
    ,
    .frame_count_o   (frame_count),
    .error_count_o   (error_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    bit            user;
    bit            last;
  } beat_t;

  // kind: 0 clean, 1 extra tlast at pos, 2 frame cut after pos beats,
  //       3 missing SOF, 4 missing EOF
  typedef struct {
    int kind;
    int pos;
    int ready_mode;   // 0 always 1, 1 toggling 1010, 2 random
    int en_drop;      // source index at which enable falls, -1 never
    bit two;          // append a clean frame after the test frame
    int exp_beats;
    int exp_done;
    bit exp_err;
    int exp_wr;       // window_reset cycles between frames, -1 unchecked
  } vec_t;

  beat_t src[$];
  beat_t exp_q[$];
  beat_t got_q[$];
  int    model_err;
  int    model_done;
  int    vectors     = 0;
  int    miscompares = 0;

  task automatic check(input string name, input longint actual, input longint required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  task automatic add_frame(input int kind, input int pos);
    int len;
    len = (kind == 2) ? pos : N;
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = 8'($urandom_range(0, 255));
      b.user = (i == 0) && (kind != 3);
      b.last = ((i == N - 1) && (kind != 4)) || ((kind == 1) && (i == pos));
      src.push_back(b);
    end
  endtask

  // Sequence-level model: walks the source beats with an expected in-frame index
  function automatic void run_model();
    int k     = 0;
    bit sync  = 1'b1;
    int i     = 0;
    int guard = 0;
    exp_q.delete();
    model_err  = 0;
    model_done = 0;
    while (i < src.size() && guard < 100000) begin
      guard++;
      if (!sync) begin
        if (src[i].user) begin
          sync = 1'b1;
          k    = 0;
        end else begin
          i++;
        end
      end else if ((src[i].user == (k == 0)) && (src[i].last == (k == N - 1))) begin
        beat_t e;
        e.data = src[i].data;
        e.user = 1'b0;
        e.last = (k == N - 1);
        exp_q.push_back(e);
        if (k == N - 1) model_done++;
        k = (k + 1) % N;
        i++;
      end else begin
        model_err++;
        if (src[i].user) begin
          k = 0;
        end else begin
          sync = 1'b0;
          i++;
        end
      end
    end
  endfunction

  task automatic do_reset();
    enable   = 1'b0;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset window_reset", win_reset, 1);
    check("reset frame_done", frame_done, 0);
    check("reset error", error, 0);
    check("reset slave_tready", s_tready, 0);
    check("reset master_tvalid", m_tvalid, 0);
    check("reset master_tlast", m_tlast, 0);
`ifdef SLIDING_WINDOW_FRAME_STATS_EN
    check("reset frame_count", frame_count, 0);
    check("reset error_count", error_count, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
  endtask

  // Drives src as an AXI-Stream source, collects forwarded beats and done pulses
  task automatic run_seq(input int ready_mode, input int en_drop, input int stop_at,
                         output int n_done, output int wr_cycles);
    int idx   = 0;
    int cyc   = 0;
    int drain = 0;
    bit acc   = 1'b0;
    got_q.delete();
    n_done    = 0;
    wr_cycles = 0;
    forever begin
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        s_tvalid = 1'b0;
      end
      if (stop_at >= 0 && idx >= stop_at) break;
      if (!s_tvalid && idx < src.size()) begin
        if (ready_mode != 2 || $urandom_range(0, 3) != 0) begin
          s_tvalid = 1'b1;
          s_tdata  = src[idx].data;
          s_tuser  = src[idx].user;
          s_tlast  = src[idx].last;
        end
      end
      if (!s_tvalid) begin
        s_tuser = 1'b0;
        s_tlast = 1'b0;
      end
      case (ready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (cyc % 2 == 0);
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
      if (en_drop >= 0 && idx >= en_drop) enable = 1'b0;
      #3;
      acc = s_tvalid && s_tready;
      if (m_tvalid && m_tready) begin
        beat_t g;
        g.data = m_tdata;
        g.user = 1'b0;
        g.last = m_tlast;
        got_q.push_back(g);
      end
      if (frame_done) n_done++;
      if (win_reset && got_q.size() > 0 && n_done < 2) wr_cycles++;
      cyc++;
      if (idx >= src.size()) drain++;
      if (drain >= 12) break;
      if (cyc >= 4000) begin
        check("run cycle budget", cyc, 0);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic compare_stream(input string tag, input int n_done);
    check({tag, " beat count vs model"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s beat%0d data/tlast", tag, i),
            {got_q[i].data, got_q[i].last}, {exp_q[i].data, exp_q[i].last});
    end
    check({tag, " frame_done pulses vs model"}, n_done, model_done);
`ifdef SLIDING_WINDOW_FRAME_STATS_EN
    check({tag, " frame_count"}, frame_count, model_done);
    check({tag, " error_count"}, error_count, model_err);
`endif
  endtask

  initial begin
    vec_t tbl[7];
    int   nd;
    int   wr;
    int   done_seen;

    tbl[0] = '{0,  0, 0, -1, 1'b1, 40, 2, 1'b0,  1};  // two clean frames
    tbl[1] = '{0,  0, 1, -1, 1'b1, 40, 2, 1'b0,  1};  // ready toggling
    tbl[2] = '{1, 11, 0, -1, 1'b1, 31, 1, 1'b1, -1};  // tlast on pixel 12
    tbl[3] = '{2,  6, 0, -1, 1'b1, 26, 1, 1'b1, -1};  // tuser on pixel 7
    tbl[4] = '{3,  0, 0, -1, 1'b1, 20, 1, 1'b1, -1};  // first beat lacks tuser
    tbl[5] = '{4,  0, 2, -1, 1'b1, 39, 1, 1'b1, -1};  // missing tlast, random ready
    tbl[6] = '{0,  0, 0,  5, 1'b0, 20, 1, 1'b0, -1};  // enable falls mid-frame

    for (int r = 0; r < 7; r++) begin
      string tag;
      tag = $sformatf("rec%0d", r);
      do_reset();
      src.delete();
      add_frame(tbl[r].kind, tbl[r].pos);
      if (tbl[r].two) add_frame(0, 0);
      run_model();
      run_seq(tbl[r].ready_mode, tbl[r].en_drop, -1, nd, wr);
      check({tag, " beat count"}, got_q.size(), tbl[r].exp_beats);
      check({tag, " frame_done pulses"}, nd, tbl[r].exp_done);
      check({tag, " error"}, error, tbl[r].exp_err);
      if (tbl[r].exp_wr >= 0) check({tag, " window_reset between frames"}, wr, tbl[r].exp_wr);
      if (tbl[r].en_drop >= 0) begin
        check({tag, " idle window_reset"}, win_reset, 1);
        check({tag, " idle slave_tready"}, s_tready, 0);
      end
      compare_stream(tag, nd);
    end

    // Reset pulsed mid-frame: outputs fall back asynchronously, no done pulse
    do_reset();
    src.delete();
    add_frame(0, 0);
    run_seq(0, -1, 10, nd, wr);
    check("midreset beats before reset", got_q.size(), 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset window_reset", win_reset, 1);
    check("midreset master_tvalid", m_tvalid, 0);
    check("midreset slave_tready", s_tready, 0);
    check("midreset error", error, 0);
`ifdef SLIDING_WINDOW_FRAME_STATS_EN
    check("midreset frame_count", frame_count, 0);
    check("midreset error_count", error_count, 0);
`endif
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (frame_done) done_seen++;
    end
    check("midreset frame_done", done_seen, 0);
    s_tvalid = 1'b0;

    // Randomized frame streams with assorted framing faults
    for (int t = 0; t < 4; t++) begin
      string tag;
      tag = $sformatf("rand%0d", t);
      do_reset();
      src.delete();
      for (int f = 0; f < 8; f++) begin
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
          5:       add_frame(1, $urandom_range(1, N - 2));
          6:       add_frame(2, $urandom_range(1, N - 1));
          7:       add_frame(3, 0);
          8:       add_frame(4, 0);
          default: add_frame(0, 0);
        endcase
      end
      add_frame(0, 0);
      run_model();
      run_seq(2, -1, -1, nd, wr);
      compare_stream(tag, nd);
      check({tag, " error"}, error, (model_err > 0) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
